// File: rtl/axis_gain_ramp_controller.sv
// Gain sequencer for the volume datapath. It synchronizes and debounces the switch/mute request,
// then slews the applied fixed-point gain toward the target by one step per stereo frame.
module axis_gain_ramp_controller #(
  parameter int SWITCH_WIDTH    = 4,
  parameter int GAIN_FRAC       = 24,
  parameter int STEP            = 65536,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SWITCH_WIDTH-1:0] sw,
  input  logic                    mute,
  input  logic                    frame_strobe,
  output logic [GAIN_FRAC:0]      gain,
  output logic                    gain_update,
  output logic                    ramping,
  output logic                    settling
);

  localparam int GW     = GAIN_FRAC + 1;
  localparam int RW     = GAIN_FRAC + 2;
  localparam int PW     = SWITCH_WIDTH + GAIN_FRAC + 1;
  localparam int RQ     = SWITCH_WIDTH + 1;
  localparam int SW_MAX = (2 ** SWITCH_WIDTH) - 1;

  typedef enum logic {IDLE, SETTLE} state_t;

  logic [SWITCH_WIDTH-1:0] r_sw_p0, r_sw_p1, r_sw_p2;
  logic                    r_mute_p0, r_mute_p1, r_mute_p2, r_mute_p3;
  state_t                  r_state, w_state_nx;
  logic [RQ-1:0]           r_cand, w_cand_nx;
  logic [7:0]              r_count, w_count_nx;
  logic [GW-1:0]           r_target, w_target_nx;
  logic [GW-1:0]           r_gain, w_gain_nx;
  logic                    r_gain_upd, r_ramping;
  logic [RQ-1:0]           w_req;
  logic                    w_mute_rise;

  // Full-scale switch maps to exactly unity; a muted candidate always maps to silence.
  function automatic logic [GW-1:0] f_tgt(input logic [RQ-1:0] c);
    logic [PW-1:0] num;
    logic [GW-1:0] q;
    num   = PW'(c[SWITCH_WIDTH-1:0]) << GAIN_FRAC;
    q     = GW'(num / PW'(SW_MAX));
    f_tgt = c[SWITCH_WIDTH] ? '0 : q;
  endfunction

  // One slew step with the final step clamped onto the target (no overshoot/undershoot).
  function automatic logic [GW-1:0] f_ramp(input logic [GW-1:0] g, input logic [GW-1:0] t);
    logic [RW-1:0] ge, te, st, sum, dif;
    ge     = {1'b0, g};
    te     = {1'b0, t};
    st     = RW'(STEP);
    sum    = ge + st;
    dif    = ge - te;
    f_ramp = g;
    if (ge < te)
      f_ramp = (sum > te) ? t : sum[GW-1:0];
    else if (ge > te)
      f_ramp = (dif <= st) ? t : (g - st[GW-1:0]);
  endfunction

  // Stage p0..p2: three-flop synchronizers; p3 keeps the previous synced mute for edge detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sw_p0   <= '0;
      r_sw_p1   <= '0;
      r_sw_p2   <= '0;
      r_mute_p0 <= 1'b0;
      r_mute_p1 <= 1'b0;
      r_mute_p2 <= 1'b0;
      r_mute_p3 <= 1'b0;
    end else begin
      r_sw_p0   <= sw;
      r_sw_p1   <= r_sw_p0;
      r_sw_p2   <= r_sw_p1;
      r_mute_p0 <= mute;
      r_mute_p1 <= r_mute_p0;
      r_mute_p2 <= r_mute_p1;
      r_mute_p3 <= r_mute_p2;
    end
  end

  assign w_req       = {r_mute_p2, r_sw_p2};
  assign w_mute_rise = r_mute_p2 & ~r_mute_p3;

  // Debounce FSM: a request change always restarts the count, even on a strobe cycle.
  always_comb begin
    w_state_nx  = r_state;
    w_cand_nx   = r_cand;
    w_count_nx  = r_count;
    w_target_nx = r_target;
    if (w_mute_rise) begin
      w_target_nx = '0;
      w_cand_nx   = w_req;
      w_count_nx  = '0;
      w_state_nx  = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req != r_cand) begin
            w_cand_nx  = w_req;
            w_count_nx = '0;
            w_state_nx = SETTLE;
          end
        end
        SETTLE: begin
          if (w_req != r_cand) begin
            w_cand_nx  = w_req;
            w_count_nx = '0;
          end else if (frame_strobe) begin
            if (r_count == 8'(DEBOUNCE_FRAMES - 1)) begin
              w_target_nx = f_tgt(r_cand);
              w_count_nx  = '0;
              w_state_nx  = IDLE;
            end else begin
              w_count_nx = r_count + 8'd1;
            end
          end
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end

  // The ramp reads the pre-edge target, so a target load on a strobe cycle acts on the next strobe.
  assign w_gain_nx = frame_strobe ? f_ramp(r_gain, r_target) : r_gain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cand     <= '0;
      r_count    <= '0;
      r_target   <= '0;
      r_gain     <= '0;
      r_gain_upd <= 1'b0;
      r_ramping  <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cand     <= w_cand_nx;
      r_count    <= w_count_nx;
      r_target   <= w_target_nx;
      r_gain     <= w_gain_nx;
      r_gain_upd <= (w_gain_nx != r_gain);
      r_ramping  <= (w_gain_nx != w_target_nx);
    end
  end

  assign gain        = r_gain;
  assign gain_update = r_gain_upd;
  assign ramping     = r_ramping;
  assign settling    = (r_state == SETTLE);

endmodule

// File: tb/tb_axis_gain_ramp_controller.sv
// Bench for axis_gain_ramp_controller: directed scenarios plus random traffic, checked by a
// frame-level reference model feeding a gain scoreboard.
module tb_axis_gain_ramp_controller;

  localparam int     SWW   = 4;
  localparam int     GF    = 24;
  localparam int     STEP  = 65536;
  localparam int     DB    = 4;
  localparam longint UNITY = 64'd1 << GF;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [SWW-1:0] sw = 4'd15;
  logic           mute = 1'b0;
  logic           frame_strobe = 1'b0;
  logic [GF:0]    gain;
  logic           gain_update, ramping, settling;

  axis_gain_ramp_controller #(
    .SWITCH_WIDTH(SWW), .GAIN_FRAC(GF), .STEP(STEP), .DEBOUNCE_FRAMES(DB)
  ) dut (
    .clk(clk), .reset(reset), .sw(sw), .mute(mute), .frame_strobe(frame_strobe),
    .gain(gain), .gain_update(gain_update), .ramping(ramping), .settling(settling)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int n_pulses = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint m_tgt(input bit mu, input int s);
    if (mu) return 0;
    return (longint'(s) << GF) / ((64'd1 << SWW) - 1);
  endfunction

  // Reference model: synced request = input 3 clocks ago; a request must hold for DB strobes.
  int     m_swp[3];
  bit     m_mp[3];
  bit     m_mprev, m_cmu, m_pend;
  int     m_csw, m_cnt, s_sw;
  bit     s_mu;
  longint m_tgtv, m_gain, nxt;
  bit     e_ramp, e_settle;
  longint exp_q[$];

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        m_swp[i] = 0;
        m_mp[i]  = 1'b0;
      end
      m_mprev = 0; m_csw = 0; m_cmu = 0; m_cnt = 0; m_pend = 0;
      m_tgtv = 0; m_gain = 0; e_ramp = 0; e_settle = 0;
      exp_q.delete();
    end else begin
      s_sw = m_swp[2];
      s_mu = m_mp[2];
      if (frame_strobe && m_gain != m_tgtv) begin
        if (m_gain < m_tgtv) nxt = (m_gain + STEP > m_tgtv) ? m_tgtv : m_gain + STEP;
        else                 nxt = (m_gain - m_tgtv <= STEP) ? m_tgtv : m_gain - STEP;
        m_gain = nxt;
        exp_q.push_back(nxt);
      end
      if (s_mu && !m_mprev) begin
        m_tgtv = 0; m_csw = s_sw; m_cmu = s_mu; m_cnt = 0; m_pend = 0;
      end else if (s_sw != m_csw || s_mu != m_cmu) begin
        m_csw = s_sw; m_cmu = s_mu; m_cnt = 0; m_pend = 1;
      end else if (m_pend && frame_strobe) begin
        m_cnt++;
        if (m_cnt == DB) begin
          m_tgtv = m_tgt(m_cmu, m_csw);
          m_pend = 0;
        end
      end
      m_mprev  = s_mu;
      m_swp[2] = m_swp[1]; m_swp[1] = m_swp[0]; m_swp[0] = int'(sw);
      m_mp[2]  = m_mp[1];  m_mp[1]  = m_mp[0];  m_mp[0]  = mute;
      e_ramp   = (m_gain != m_tgtv);
      e_settle = m_pend;
    end
  end

  // Monitor: pops one expected gain per gain_update pulse.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      chk("ramping", ramping, e_ramp);
      chk("settling", settling, e_settle);
      if (gain_update) begin
        n_pulses++;
        if (exp_q.size() == 0) chk("spurious_update_qsize", exp_q.size(), 1);
        else                   chk("gain_on_update", gain, exp_q.pop_front());
      end else if (exp_q.size() != 0) begin
        chk("missed_update", gain_update, 1);
        exp_q.delete();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic strobe_n(input int n);
    for (int i = 0; i < n; i++) begin
      frame_strobe = 1'b1;
      tick();
      frame_strobe = 1'b0;
      repeat (7) tick();
    end
  endtask

  task automatic powerup();
    int p0;
    reset = 1'b0;
    repeat (3) tick();
    chk("pu_settling_early", settling, 0);
    tick();
    chk("pu_settling_rise", settling, 1);
    strobe_n(DB);
    chk("pu_gain_after_debounce", gain, 0);
    chk("pu_ramping_rise", ramping, 1);
    p0 = n_pulses;
    strobe_n(256);
    chk("pu_gain_unity", gain, UNITY);
    chk("pu_ramping_fall", ramping, 0);
    chk("pu_pulse_count", n_pulses - p0, 256);
  endtask

  initial begin
    int p0;
    repeat (3) tick();
    chk("rst_gain", gain, 0);
    chk("rst_update", gain_update, 0);
    chk("rst_ramping", ramping, 0);
    chk("rst_settling", settling, 0);

    powerup();

    sw = 4'd1;
    repeat (5) tick();
    strobe_n(DB);
    chk("down_ramping", ramping, 1);
    strobe_n(238);
    chk("down_before_clamp", gain, 1179648);
    strobe_n(1);
    chk("down_clamped", gain, 1118481);
    chk("down_ramping_fall", ramping, 0);

    sw = 4'd15;
    repeat (5) tick();
    strobe_n(DB + 239);
    chk("up_again_unity", gain, UNITY);
    p0 = n_pulses;
    for (int i = 0; i < 10; i++) begin
      sw = (i % 2 == 0) ? 4'd8 : 4'd9;
      strobe_n(2);
    end
    chk("bounce_gain", gain, UNITY);
    chk("bounce_no_pulses", n_pulses - p0, 0);
    strobe_n(DB + 110);
    chk("sw9_gain", gain, 10066329);

    sw = 4'd15;
    repeat (5) tick();
    strobe_n(DB + 110);
    chk("mute_pre_unity", gain, UNITY);
    mute = 1'b1;
    repeat (3) tick();
    chk("mute_ramping_early", ramping, 0);
    tick();
    chk("mute_fast_target", ramping, 1);
    chk("mute_no_settle", settling, 0);
    strobe_n(256);
    chk("mute_gain_zero", gain, 0);
    chk("mute_ramping_done", ramping, 0);
    mute = 1'b0;
    repeat (4) tick();
    chk("unmute_settling", settling, 1);
    strobe_n(DB - 1);
    chk("unmute_still_silent", ramping, 0);
    strobe_n(1);
    chk("unmute_target", ramping, 1);
    strobe_n(256);
    chk("unmute_unity", gain, UNITY);

    sw = 4'd0;
    repeat (5) tick();
    strobe_n(DB + 256);
    chk("to_zero", gain, 0);
    sw = 4'd15;
    repeat (5) tick();
    strobe_n(DB + 124);
    chk("part_up", gain, 8126464);
    sw = 4'd0;
    repeat (5) tick();
    strobe_n(DB - 1);
    chk("debounce_still_up", gain, 8323072);
    strobe_n(1);
    chk("coincident_old_target", gain, 8388608);
    strobe_n(1);
    chk("reversed_step", gain, 8323072);
    strobe_n(63);
    chk("mid_ramp_gain", gain, 4194304);

    sw = 4'd15;
    #1 reset = 1'b1;
    #1;
    chk("async_rst_gain", gain, 0);
    chk("async_rst_ramping", ramping, 0);
    chk("async_rst_settling", settling, 0);
    chk("async_rst_update", gain_update, 0);
    repeat (2) tick();
    powerup();

    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 59) == 0) sw = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 199) == 0) mute = ~mute;
      frame_strobe = ($urandom_range(0, 2) == 0);
      tick();
    end
    frame_strobe = 1'b0;
    repeat (8) tick();
    chk("final_gain", gain, m_gain);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
